ex_wb_scheduler: RTL and testbench

- Issue scheduler between decode and the EX stage for the multithreaded pipeline.
- The ALU result path and the pipelined multiplier path share one register-file writeback port.
- The block tracks every in-flight writing instruction in a shift-register reservation table and grants issue only when the writeback slot is free and no RAW/WAW hazard against an in-flight multiply exists.
- It drives the writeback select, thread and destination for the WB stage, and supports per-thread flush.

---
 rtl/ex_wb_scheduler.sv | 98 +++++++++
 tb/tb_ex_wb_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ex_wb_scheduler.sv
// ex_wb_scheduler: issue gate and shift-register writeback reservation table for the shared ALU/MUL regfile port.
module ex_wb_scheduler #(
   parameter int THREAD_W = 2,
   parameter int REG_W    = 5,
   parameter int ALU_LAT  = 3,
   parameter int MUL_LAT  = 5,
   localparam int CNT_W   = $clog2(MUL_LAT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic [THREAD_W-1:0] issue_thread,
   input  logic                issue_is_mul,
   input  logic                issue_writes,
   input  logic [REG_W-1:0]    issue_dst,
   input  logic [REG_W-1:0]    issue_src1,
   input  logic [REG_W-1:0]    issue_src2,
   output logic                issue_grant,
   output logic                issue_stall,
   input  logic                flush_valid,
   input  logic [THREAD_W-1:0] flush_thread,
   output logic                wb_valid,
   output logic                wb_is_mul,
   output logic [THREAD_W-1:0] wb_thread,
   output logic [REG_W-1:0]    wb_dst,
   output logic [CNT_W-1:0]    mul_inflight
);
   logic [MUL_LAT-1:0]  r_vld, r_mul, w_nvld, w_nmul;
   logic [THREAD_W-1:0] r_thr [MUL_LAT];
   logic [THREAD_W-1:0] w_nthr [MUL_LAT];
   logic [REG_W-1:0]    r_dst [MUL_LAT];
   logic [REG_W-1:0]    w_ndst [MUL_LAT];
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic                w_wr, w_struct, w_raw, w_waw, w_fl_iss, w_ins;
   int                  w_tgt;
   // r0 writes never occupy a slot, so they neither reserve nor contend for one
   assign w_wr     = issue_writes & (|issue_dst);
   assign w_struct = w_wr & ~issue_is_mul & r_vld[ALU_LAT];
   assign w_fl_iss = flush_valid & (flush_thread == issue_thread);
   assign issue_grant = issue_valid & ~w_struct & ~w_raw & ~w_waw & ~w_fl_iss;
   assign issue_stall = issue_valid & ~issue_grant;
   assign w_ins    = issue_grant & w_wr;
   assign w_tgt    = issue_is_mul ? MUL_LAT - 1 : ALU_LAT - 1;
   always_comb begin
      w_raw = 1'b0;
      w_waw = 1'b0;
      for (int i = 0; i < MUL_LAT; i++) begin
         if (i >= 1 && r_vld[i] && r_mul[i] && r_thr[i] == issue_thread &&
             ((issue_src1 != '0 && r_dst[i] == issue_src1) || (issue_src2 != '0 && r_dst[i] == issue_src2)))
            w_raw = 1'b1;
         if (w_wr && r_vld[i] && r_mul[i] && r_thr[i] == issue_thread && r_dst[i] == issue_dst)
            w_waw = 1'b1;
      end
   end
   always_comb begin
      w_nvld = '0;
      w_nmul = '0;
      w_cnt  = '0;
      for (int i = 0; i < MUL_LAT - 1; i++) begin
         w_nvld[i] = r_vld[i+1];
         w_nmul[i] = r_mul[i+1];
         w_nthr[i] = r_thr[i+1];
         w_ndst[i] = r_dst[i+1];
      end
      w_nthr[MUL_LAT-1] = '0;
      w_ndst[MUL_LAT-1] = '0;
      for (int i = 0; i < MUL_LAT; i++) begin
         if (w_ins && i == w_tgt) begin
            w_nvld[i] = 1'b1;
            w_nmul[i] = issue_is_mul;
            w_nthr[i] = issue_thread;
            w_ndst[i] = issue_dst;
         end
         if (flush_valid && w_nthr[i] == flush_thread) w_nvld[i] = 1'b0;
         w_cnt = w_cnt + CNT_W'(w_nvld[i] & w_nmul[i]);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         r_mul <= '0;
         r_thr <= '{default: '0};
         r_dst <= '{default: '0};
         r_cnt <= '0;
      end else begin
         r_vld <= w_nvld;
         r_mul <= w_nmul;
         r_thr <= w_nthr;
         r_dst <= w_ndst;
         r_cnt <= w_cnt;
      end
   end
   assign wb_valid     = r_vld[0] & ~(flush_valid & (r_thr[0] == flush_thread));
   assign wb_is_mul    = wb_valid & r_mul[0];
   assign wb_thread    = wb_valid ? r_thr[0] : '0;
   assign wb_dst       = wb_valid ? r_dst[0] : '0;
   assign mul_inflight = r_cnt;
endmodule

// File: tb/tb_ex_wb_scheduler.sv
// tb_ex_wb_scheduler: directed vector table plus hand-written multi-cycle hazard, flush and reset sequences.
module tb_ex_wb_scheduler;
   logic       clk = 1'b0, rst = 1'b1;
   logic       issue_valid, issue_is_mul, issue_writes, flush_valid;
   logic [1:0] issue_thread, flush_thread, wb_thread;
   logic [4:0] issue_dst, issue_src1, issue_src2, wb_dst;
   logic       issue_grant, issue_stall, wb_valid, wb_is_mul;
   logic [2:0] mul_inflight;
   int         total = 0, bad = 0;
   typedef struct {
      logic       v, m, w, g, wv, wm;
      logic [1:0] t, wt;
      logic [4:0] d, s1, s2, wd;
      logic [2:0] mi;
   } vec_t;
   vec_t tbl[$];
   always #5 clk = ~clk;
   ex_wb_scheduler #(.THREAD_W(2), .REG_W(5), .ALU_LAT(3), .MUL_LAT(5)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_thread(issue_thread),
      .issue_is_mul(issue_is_mul), .issue_writes(issue_writes), .issue_dst(issue_dst),
      .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_grant(issue_grant),
      .issue_stall(issue_stall), .flush_valid(flush_valid), .flush_thread(flush_thread),
      .wb_valid(wb_valid), .wb_is_mul(wb_is_mul), .wb_thread(wb_thread), .wb_dst(wb_dst),
      .mul_inflight(mul_inflight));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask
   task automatic iss(input int v, input int t, input int m, input int w, input int d, input int s1, input int s2);
      issue_valid = v[0]; issue_thread = t[1:0]; issue_is_mul = m[0]; issue_writes = w[0];
      issue_dst = d[4:0]; issue_src1 = s1[4:0]; issue_src2 = s2[4:0];
   endtask
   task automatic flush(input int v, input int t);
      flush_valid = v[0]; flush_thread = t[1:0];
   endtask
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   task automatic chk_wb(input string nm, input int v, input int m, input int t, input int d);
      chk({nm, ".wb_valid"}, 32'(wb_valid), v);
      chk({nm, ".wb_is_mul"}, 32'(wb_is_mul), m);
      chk({nm, ".wb_thread"}, 32'(wb_thread), t);
      chk({nm, ".wb_dst"}, 32'(wb_dst), d);
   endtask
   function automatic void add(input int v, input int t, input int m, input int w, input int d, input int s1,
                               input int s2, input int g, input int wv, input int wm, input int wt, input int wd,
                               input int mi);
      vec_t e;
      e.v = v[0]; e.t = t[1:0]; e.m = m[0]; e.w = w[0]; e.d = d[4:0]; e.s1 = s1[4:0]; e.s2 = s2[4:0];
      e.g = g[0]; e.wv = wv[0]; e.wm = wm[0]; e.wt = wt[1:0]; e.wd = wd[4:0]; e.mi = mi[2:0];
      tbl.push_back(e);
   endfunction
   function automatic void idle_v(input int wv, input int wm, input int wt, input int wd, input int mi);
      add(0, 0, 0, 0, 0, 0, 0, 0, wv, wm, wt, wd, mi);
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end
   initial begin
      // lone ALU op: wb only in c+3
      add(1, 1, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0);
      idle_v(0, 0, 0, 0, 0); idle_v(0, 0, 0, 0, 0);
      idle_v(1, 0, 1, 7, 0); idle_v(0, 0, 0, 0, 0);
      // writeback collision: mul t0 d4, ALU t1 d6 stalls once
      add(1, 0, 1, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0);
      idle_v(0, 0, 0, 0, 1);
      add(1, 1, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 1);
      idle_v(0, 0, 0, 0, 1);
      idle_v(1, 1, 0, 4, 1);
      idle_v(1, 0, 1, 6, 0);
      idle_v(0, 0, 0, 0, 0);
      // r0 writes take no slot
      add(1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) idle_v(0, 0, 0, 0, 0);
      iss(0, 0, 0, 0, 0, 0, 0);
      flush(0, 0);
      #1;
      chk("reset.wb_valid", 32'(wb_valid), 0);
      chk("reset.mul_inflight", 32'(mul_inflight), 0);
      chk_wb("reset", 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      foreach (tbl[k]) begin
         iss(tbl[k].v, tbl[k].t, tbl[k].m, tbl[k].w, tbl[k].d, tbl[k].s1, tbl[k].s2);
         #1;
         chk($sformatf("vec%0d.grant", k), 32'(issue_grant), 32'(tbl[k].g));
         chk($sformatf("vec%0d.stall", k), 32'(issue_stall), 32'(tbl[k].v & ~tbl[k].g));
         chk_wb($sformatf("vec%0d", k), tbl[k].wv, tbl[k].wm, tbl[k].wt, tbl[k].wd);
         chk($sformatf("vec%0d.mul_inflight", k), 32'(mul_inflight), 32'(tbl[k].mi));
         tick;
      end
      // RAW against in-flight mul
      iss(1, 0, 1, 1, 4, 0, 0); #1 chk("raw.mul_grant", 32'(issue_grant), 1);
      for (int k = 1; k <= 5; k++) begin
         tick; iss(1, 0, 0, 1, 8, 4, 0); #1;
         chk($sformatf("raw.c%0d.grant", k), 32'(issue_grant), 32'(k == 5));
      end
      chk_wb("raw.c5", 1, 1, 0, 4);
      tick; iss(0, 0, 0, 0, 0, 0, 0);
      repeat (4) tick;
      // other thread sees no RAW
      iss(1, 0, 1, 1, 4, 0, 0); #1;
      tick; iss(1, 1, 0, 1, 8, 4, 0); #1 chk("raw_t1.grant", 32'(issue_grant), 1);
      tick; iss(0, 0, 0, 0, 0, 0, 0);
      repeat (6) tick;
      // WAW holds until the mul has left the table entirely
      iss(1, 0, 1, 1, 4, 0, 0); #1;
      for (int k = 1; k <= 6; k++) begin
         tick; iss(1, 0, 0, 1, 4, 0, 0); #1;
         chk($sformatf("waw.c%0d.grant", k), 32'(issue_grant), 32'(k == 6));
      end
      tick; iss(0, 0, 0, 0, 0, 0, 0);
      repeat (4) tick;
      // flush of t2 leaves t3 alone
      iss(1, 2, 1, 1, 3, 0, 0); #1 chk("fl.c0.grant", 32'(issue_grant), 1);
      tick; iss(1, 3, 1, 1, 5, 0, 0); #1 chk("fl.c1.grant", 32'(issue_grant), 1);
      tick; iss(1, 2, 0, 1, 1, 0, 0); flush(1, 2); #1;
      chk("fl.c2.grant", 32'(issue_grant), 0);
      chk("fl.c2.stall", 32'(issue_stall), 1);
      chk("fl.c2.mul_inflight", 32'(mul_inflight), 2);
      tick; iss(0, 0, 0, 0, 0, 0, 0); flush(0, 0); #1 chk("fl.c3.mul_inflight", 32'(mul_inflight), 1);
      tick; tick; #1 chk_wb("fl.c5", 0, 0, 0, 0);
      tick; #1 chk_wb("fl.c6", 1, 1, 3, 5);
      tick; repeat (2) tick;
      // flush masks slot[0] of the flushed thread only
      iss(1, 1, 0, 1, 2, 0, 0); #1 chk("flwb.c0.grant", 32'(issue_grant), 1);
      tick; iss(1, 0, 0, 1, 3, 0, 0); #1 chk("flwb.c1.grant", 32'(issue_grant), 1);
      tick; iss(0, 0, 0, 0, 0, 0, 0);
      tick; flush(1, 1); #1 chk_wb("flwb.c3", 0, 0, 0, 0);
      tick; #1 chk_wb("flwb.c4", 1, 0, 0, 3);
      tick; flush(0, 0);
      repeat (3) tick;
      // async reset mid-flight
      iss(1, 1, 1, 1, 9, 0, 0); #1 chk("rst.c0.grant", 32'(issue_grant), 1);
      tick; iss(0, 0, 0, 0, 0, 0, 0); #1 chk("rst.c1.mul_inflight", 32'(mul_inflight), 1);
      tick; rst = 1'b1; #1;
      chk("rst.c2.mul_inflight", 32'(mul_inflight), 0);
      chk("rst.c2.wb_valid", 32'(wb_valid), 0);
      #1 rst = 1'b0;
      for (int k = 3; k <= 8; k++) begin
         tick; #1 chk($sformatf("rst.c%0d.wb_valid", k), 32'(wb_valid), 0);
      end
      iss(1, 1, 1, 1, 9, 0, 0); #1 chk("rst.after.grant", 32'(issue_grant), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
